// File: rtl/nn_ddr2_arbiter.sv
// Two-port arbiter/sequencer in front of the DDR2 controller local interface.
// Port 0 (display reads) has fixed priority; port 1 (cache) is guaranteed service via skip_cnt.
module nn_ddr2_arbiter #(
    parameter int ADDR_W       = 24,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 1023
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                p0_req,
    input  logic [ADDR_W-1:0]   p0_addr,
    output logic                p0_ack,
    output logic                p0_rvalid,
    output logic [DATA_W-1:0]   p0_rdata,
    input  logic                p1_req,
    input  logic                p1_we,
    input  logic [ADDR_W-1:0]   p1_addr,
    input  logic [DATA_W-1:0]   p1_wdata,
    output logic                p1_ack,
    output logic                p1_rvalid,
    output logic [DATA_W-1:0]   p1_rdata,
    input  logic                local_init_done,
    input  logic                local_ready,
    output logic                local_read_req,
    output logic                local_write_req,
    output logic                local_burstbegin,
    output logic                local_size,
    output logic [DATA_W/8-1:0] local_be,
    output logic [ADDR_W-1:0]   local_address,
    output logic [DATA_W-1:0]   local_wdata,
    input  logic [DATA_W-1:0]   local_rdata,
    input  logic                local_rdata_valid,
    output logic                err
);

    typedef enum logic [1:0] {INIT, IDLE, ISSUE, WAIT_RD} state_t;

    state_t              state, state_d;
    logic                owner, owner_d;
    logic                we_q, we_d;
    logic [3:0]          skip_cnt, skip_d;
    logic [11:0]         tmo_cnt, tmo_d;
    logic                err_d;
    logic                ack0_d, ack1_d, rv0_d, rv1_d;
    logic [DATA_W-1:0]   rdata0_d, rdata1_d, wdata_d;
    logic [ADDR_W-1:0]   addr_d;
    logic                rd_d, wr_d, bb_d;
    logic                grant1;

    assign local_size = 1'b1;
    assign local_be   = '1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= INIT;
            owner            <= 1'b0;
            we_q             <= 1'b0;
            skip_cnt         <= '0;
            tmo_cnt          <= '0;
            err              <= 1'b0;
            p0_ack           <= 1'b0;
            p1_ack           <= 1'b0;
            p0_rvalid        <= 1'b0;
            p1_rvalid        <= 1'b0;
            p0_rdata         <= '0;
            p1_rdata         <= '0;
            local_address    <= '0;
            local_wdata      <= '0;
            local_read_req   <= 1'b0;
            local_write_req  <= 1'b0;
            local_burstbegin <= 1'b0;
        end else begin
            state            <= state_d;
            owner            <= owner_d;
            we_q             <= we_d;
            skip_cnt         <= skip_d;
            tmo_cnt          <= tmo_d;
            err              <= err_d;
            p0_ack           <= ack0_d;
            p1_ack           <= ack1_d;
            p0_rvalid        <= rv0_d;
            p1_rvalid        <= rv1_d;
            p0_rdata         <= rdata0_d;
            p1_rdata         <= rdata1_d;
            local_address    <= addr_d;
            local_wdata      <= wdata_d;
            local_read_req   <= rd_d;
            local_write_req  <= wr_d;
            local_burstbegin <= bb_d;
        end
    end

    always_comb begin
        state_d  = state;
        owner_d  = owner;
        we_d     = we_q;
        skip_d   = skip_cnt;
        tmo_d    = tmo_cnt;
        err_d    = err;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rv0_d    = 1'b0;
        rv1_d    = 1'b0;
        rdata0_d = p0_rdata;
        rdata1_d = p1_rdata;
        addr_d   = local_address;
        wdata_d  = local_wdata;
        rd_d     = local_read_req;
        wr_d     = local_write_req;
        bb_d     = local_burstbegin;
        grant1   = 1'b0;

        case (state)
            INIT: begin
                if (local_init_done) state_d = IDLE;
            end
            IDLE: begin
                // A requester still sees its ack this cycle and holds req; don't re-grant it.
                if (!p0_ack && !p1_ack && (p0_req || p1_req)) begin
                    grant1 = p1_req && (!p0_req || skip_cnt == 4'(STARVE_LIMIT));
                    if (grant1) begin
                        owner_d = 1'b1;
                        we_d    = p1_we;
                        addr_d  = p1_addr;
                        wdata_d = p1_wdata;
                        skip_d  = '0;
                    end else begin
                        owner_d = 1'b0;
                        we_d    = 1'b0;
                        addr_d  = p0_addr;
                        wdata_d = '0;
                        if (p1_req) skip_d = skip_cnt + 4'd1;
                    end
                    rd_d    = !we_d;
                    wr_d    = we_d;
                    bb_d    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (local_ready) begin
                    rd_d   = 1'b0;
                    wr_d   = 1'b0;
                    bb_d   = 1'b0;
                    ack0_d = !owner;
                    ack1_d = owner;
                    if (we_q) begin
                        state_d = IDLE;
                    end else begin
                        tmo_d   = '0;
                        state_d = WAIT_RD;
                    end
                end
            end
            WAIT_RD: begin
                if (local_rdata_valid) begin
                    if (owner) begin
                        rv1_d    = 1'b1;
                        rdata1_d = local_rdata;
                    end else begin
                        rv0_d    = 1'b1;
                        rdata0_d = local_rdata;
                    end
                    state_d = IDLE;
                end else if (tmo_cnt == 12'(TIMEOUT - 1)) begin
                    // Fires exactly TIMEOUT edges after entering WAIT_RD.
                    err_d = 1'b1;
                    if (owner) begin
                        rv1_d    = 1'b1;
                        rdata1_d = '0;
                    end else begin
                        rv0_d    = 1'b1;
                        rdata0_d = '0;
                    end
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_cnt + 12'd1;
                end
            end
            default: state_d = INIT;
        endcase
    end

endmodule

// File: tb/tb_nn_ddr2_arbiter.sv
// Directed self-checking bench for nn_ddr2_arbiter: init, reads, backpressured write,
// starvation ordering, read timeout and mid-transaction reset.
module tb_nn_ddr2_arbiter;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 64;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                p0_req;
    logic [ADDR_W-1:0]   p0_addr;
    logic                p0_ack, p0_rvalid;
    logic [DATA_W-1:0]   p0_rdata;
    logic                p1_req, p1_we;
    logic [ADDR_W-1:0]   p1_addr;
    logic [DATA_W-1:0]   p1_wdata;
    logic                p1_ack, p1_rvalid;
    logic [DATA_W-1:0]   p1_rdata;
    logic                local_init_done, local_ready;
    logic                local_read_req, local_write_req, local_burstbegin, local_size;
    logic [DATA_W/8-1:0] local_be;
    logic [ADDR_W-1:0]   local_address;
    logic [DATA_W-1:0]   local_wdata, local_rdata;
    logic                local_rdata_valid;
    logic                err;

    int n_tests = 0;
    int n_fail  = 0;

    nn_ddr2_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4), .TIMEOUT(1023)) dut (
        .clk(clk), .reset_n(reset_n),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_ack(p0_ack),
        .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .local_init_done(local_init_done), .local_ready(local_ready),
        .local_read_req(local_read_req), .local_write_req(local_write_req),
        .local_burstbegin(local_burstbegin), .local_size(local_size), .local_be(local_be),
        .local_address(local_address), .local_wdata(local_wdata),
        .local_rdata(local_rdata), .local_rdata_valid(local_rdata_valid),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int seen, hi, acks, ng, bad;

        reset_n = 1'b0; local_init_done = 1'b0; local_ready = 1'b0;
        local_rdata = '0; local_rdata_valid = 1'b0;
        p0_req = 1'b1; p0_addr = 24'h000123;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;

        // Reset with a pending request
        repeat (3) tick();
        chk("rst_strobes", 64'({local_read_req, local_write_req, local_burstbegin}), 64'd0);
        chk("rst_acks", 64'({p0_ack, p1_ack, p0_rvalid, p1_rvalid}), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_addr", 64'(local_address), 64'd0);
        chk("rst_size_be", 64'({local_size, local_be}), 64'h1FF);

        // Calibration not done: no strobes for 50 cycles
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (local_read_req || local_write_req || local_burstbegin) seen++;
        end
        chk("init_no_strobe", 64'(seen), 64'd0);

        local_init_done = 1'b1;
        tick();
        chk("init_edge1", 64'(local_read_req), 64'd0);
        tick();
        chk("init_edge2_rd", 64'({local_read_req, local_burstbegin, local_write_req}), 64'b110);
        chk("rd0_addr", 64'(local_address), 64'h000123);

        // Single port-0 read
        local_ready = 1'b1;
        tick();
        chk("rd0_ack", 64'(p0_ack), 64'd1);
        chk("rd0_strobe_drop", 64'(local_read_req), 64'd0);
        p0_req = 1'b0; local_ready = 1'b0;
        tick();
        chk("rd0_ack_pulse", 64'(p0_ack), 64'd0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (p0_rvalid || p1_rvalid) bad++;
        end
        chk("rd0_early_rvalid", 64'(bad), 64'd0);
        local_rdata = 64'hDEADBEEF_00000001; local_rdata_valid = 1'b1;
        tick();
        chk("rd0_rvalid", 64'({p0_rvalid, p1_rvalid}), 64'b10);
        chk("rd0_rdata", p0_rdata, 64'hDEADBEEF_00000001);
        local_rdata_valid = 1'b0; local_rdata = '0;
        tick();
        chk("rd0_rvalid_pulse", 64'(p0_rvalid), 64'd0);
        chk("rd0_rdata_hold", p0_rdata, 64'hDEADBEEF_00000001);

        // Port-1 write with 4 cycles of backpressure; inputs change after grant
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 24'h00FFFF; p1_wdata = 64'h5555_5555_5555_5555;
        tick();
        hi = 0; acks = 0;
        for (int i = 0; i < 5; i++) begin
            if (local_write_req && !local_read_req && local_burstbegin &&
                local_address == 24'h00FFFF && local_wdata == 64'h5555_5555_5555_5555) hi++;
            if (p1_ack || p0_ack) acks++;
            if (i == 1) begin p1_addr = 24'h0; p1_wdata = 64'h0; end
            if (i == 4) local_ready = 1'b1;
            tick();
        end
        chk("wr_held_cycles", 64'(hi), 64'd5);
        chk("wr_early_ack", 64'(acks), 64'd0);
        chk("wr_ack", 64'({p1_ack, p0_ack}), 64'b10);
        chk("wr_strobe_drop", 64'(local_write_req), 64'd0);
        local_ready = 1'b0;
        tick();
        chk("wr_no_regrant", 64'({local_write_req, local_read_req}), 64'd0);
        chk("wr_ack_pulse", 64'(p1_ack), 64'd0);
        p1_req = 1'b0; p1_we = 1'b0;
        tick();

        // Starvation limit: both reads held, data returned immediately
        p0_req = 1'b1; p0_addr = 24'h000010; p1_req = 1'b1; p1_addr = 24'h000020;
        local_ready = 1'b1; local_rdata_valid = 1'b1; local_rdata = 64'hA5A5_0000_0000_0042;
        ng = 0;
        for (int c = 0; c < 60 && ng < 10; c++) begin
            tick();
            if (p0_ack || p1_ack) begin
                chk($sformatf("starve_grant%0d", ng), 64'({p1_ack, p0_ack}),
                    (ng == 4 || ng == 9) ? 64'b10 : 64'b01);
                ng++;
            end
        end
        chk("starve_count", 64'(ng), 64'd10);
        p0_req = 1'b0; p1_req = 1'b0;
        tick();
        chk("starve_p1_rvalid", 64'(p1_rvalid), 64'd1);
        chk("starve_p1_rdata", p1_rdata, 64'hA5A5_0000_0000_0042);
        local_rdata_valid = 1'b0; local_ready = 1'b0; local_rdata = 64'h1111_2222_3333_4444;
        tick();

        // Port-1 read timeout
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 24'h000777; local_ready = 1'b1;
        tick();
        tick();
        chk("tmo_ack", 64'(p1_ack), 64'd1);
        p1_req = 1'b0; local_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < 1022; i++) begin
            tick();
            if (err || p1_rvalid || p0_rvalid) bad++;
        end
        chk("tmo_not_early", 64'(bad), 64'd0);
        tick();
        chk("tmo_err", 64'(err), 64'd1);
        chk("tmo_rvalid", 64'({p1_rvalid, p0_rvalid}), 64'b10);
        chk("tmo_rdata_zero", p1_rdata, 64'd0);
        tick();
        chk("tmo_err_sticky", 64'({err, p1_rvalid}), 64'b10);
        local_rdata_valid = 1'b1;
        tick();
        chk("stray_rvalid", 64'({p0_rvalid, p1_rvalid}), 64'd0);
        local_rdata_valid = 1'b0;

        // Reset while in WAIT_RD
        p0_req = 1'b1; p0_addr = 24'h0000AA; local_ready = 1'b1;
        tick();
        tick();
        chk("mid_ack", 64'(p0_ack), 64'd1);
        p0_req = 1'b0; local_ready = 1'b0;
        tick();
        reset_n = 1'b0;
        #2;
        chk("mid_rst_err", 64'(err), 64'd0);
        chk("mid_rst_rdata", p0_rdata, 64'd0);
        local_rdata_valid = 1'b1; local_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        chk("mid_rst_rvalid", 64'({p0_rvalid, p1_rvalid}), 64'd0);
        reset_n = 1'b1;
        tick();
        chk("post_rst_rvalid", 64'({p0_rvalid, p1_rvalid, err}), 64'd0);
        local_rdata_valid = 1'b0;

        p0_req = 1'b1; p0_addr = 24'h000ABC; local_ready = 1'b1;
        tick();
        chk("post_rd_req", 64'({local_read_req, local_address}), {39'd0, 1'b1, 24'h000ABC});
        tick();
        chk("post_ack", 64'(p0_ack), 64'd1);
        p0_req = 1'b0; local_ready = 1'b0;
        local_rdata_valid = 1'b1; local_rdata = 64'h0123_4567_89AB_CDEF;
        tick();
        chk("post_rvalid", 64'(p0_rvalid), 64'd1);
        chk("post_rdata", p0_rdata, 64'h0123_4567_89AB_CDEF);
        local_rdata_valid = 1'b0;
        tick();
        chk("post_idle", 64'({p0_rvalid, err}), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nn_ddr2_arbiter.md
# nn_ddr2_arbiter

Two-port arbiter and sequencer that shares the DDR2 controller local interface between the display read stream (port 0) and the cache (port 1). It sits between the requesters and the ddr2_ctrl local_* port in the same clk1 domain. It issues single-beat transactions, keeps at most one read outstanding, and routes read data back to the owning port. Port 0 has fixed priority, and a starvation limit guarantees that port 1 makes forward progress.

## Interface
- ADDR_W, 24, word address width (local_address)
- DATA_W, 64, local data width
- STARVE_LIMIT, 4, max consecutive port-0 grants while port 1 waits (1..15)
- TIMEOUT, 1023, max cycles waiting for read data (<2^12)

Ports:
- clk  in  1  system clock (clk1)
- reset_n  in  1  asynchronous, active-low reset
- p0_req  in  1  display read request, held until p0_ack
- p0_addr  in  ADDR_W  display read address
- p0_ack  out  1  one-cycle pulse: request accepted by DDR2
- p0_rvalid  out  1  one-cycle pulse: p0_rdata valid
- p0_rdata  out  DATA_W  read data for port 0
- p1_req  in  1  cache request, held until p1_ack
- p1_we  in  1  1 = write, 0 = read
- p1_addr  in  ADDR_W  cache address
- p1_wdata  in  DATA_W  cache write data
- p1_ack, p1_rvalid, p1_rdata  out  1/1/DATA_W  as for port 0
- local_init_done  in  1  DDR2 calibration complete
- local_ready  in  1  controller accepts request this cycle
- local_read_req, local_write_req, local_burstbegin  out  1  request strobes
- local_size  out  1  constant 1
- local_be  out  DATA_W/8  all ones
- local_address  out  ADDR_W
- local_wdata  out  DATA_W
- local_rdata  in  DATA_W
- local_rdata_valid  in  1
- err  out  1  sticky read-timeout flag

## Operation
- States: INIT, IDLE, ISSUE, WAIT_RD. All outputs are registered.
- INIT: no requests are issued. When local_init_done is sampled 1, go to IDLE. Deassertion of init_done after INIT is ignored.
- IDLE grant rule:
  - Only p0_req: grant port 0.
  - Only p1_req: grant port 1.
  - Both: grant port 1 if skip_cnt == STARVE_LIMIT, else grant port 0 and increment skip_cnt.
  - skip_cnt clears on every port-1 grant.
  - skip_cnt is unchanged when port 0 is granted with no p1_req.
- On grant:
  - Latch owner, we (port 0 always reads), addr, wdata.
  - Drive local_address/local_wdata from the latched values.
  - Assert local_read_req or local_write_req together with local_burstbegin.
  - Go to ISSUE.
- ISSUE: hold the strobes until local_ready is sampled 1. On that edge:
  - Drop the strobes.
  - Pulse the owner's ack.
  - Write: go to IDLE. Read: clear tmo_cnt and go to WAIT_RD.
- WAIT_RD:
  - On local_rdata_valid: latch local_rdata into the owner's rdata, pulse the owner's rvalid, go to IDLE.
  - If tmo_cnt reaches TIMEOUT: set err, pulse the owner's rvalid with rdata=0, go to IDLE.
- local_rdata_valid outside WAIT_RD is ignored.
- The request is latched at grant. Requester inputs that change after grant do not affect the transaction in flight.
- A requester that drops req before its ack is a protocol violation. The transaction still completes and the ack still pulses.

## Timing
- Reset (async assert):
  - State INIT, skip_cnt 0, tmo_cnt 0, err 0.
  - All ack/rvalid/strobes 0.
  - local_address/wdata/p*_rdata 0.
  - local_size 1, local_be all ones.
- Reset mid-transaction abandons it; no ack or rvalid is produced.
- Grant latency: req sampled at edge N → strobes high after N.
- Acceptance: if local_ready=1 at N+1 → ack high for N+1..N+2 and strobes low after N+1.
- Minimum spacing: one write every 3 cycles (IDLE, ISSUE, IDLE). A new grant is not made in the same cycle as ack.
- Read return: rdata_valid sampled at edge M → rvalid/rdata valid after M for one cycle.
- Timeout: err sets TIMEOUT cycles after entry to WAIT_RD.
- rdata holds its value until the next rvalid for the same port.

## Test plan
- Reset/init:
  - reset_n low with p0_req=1 → all strobes and acks 0.
  - init_done held 0 for 50 cycles → no strobe.
  - init_done=1 → local_read_req rises exactly 2 edges later.
- Single read, port 0:
  - addr 0x000123, local_ready=1, rdata 0xDEADBEEF_00000001 returned 5 cycles later.
  - Expect: p0_ack one cycle, p0_rvalid one cycle with that data, p1_rvalid stays 0.
- Write with backpressure:
  - p1_we=1, addr 0x00FFFF, wdata 0x55…55, local_ready low for 4 cycles.
  - Expect: local_write_req held 5 cycles with stable address/data, then one p1_ack.
- Starvation:
  - p0_req and p1_req held permanently (reads), STARVE_LIMIT=4, rdata returned immediately.
  - Expect grant order 0,0,0,0,1,0,0,0,0,1.
- Timeout:
  - Port 1 read, rdata_valid never asserted, TIMEOUT=1023.
  - Expect: err=1 and p1_rvalid with rdata 0 after 1023 cycles in WAIT_RD.
  - A stray rdata_valid afterwards in IDLE → no rvalid.
- Mid-op reset:
  - reset_n pulsed low while in WAIT_RD.
  - Expect: no rvalid, err 0.
  - After re-init, the next read completes normally.
